// File: rtl/protobuf_pkg.sv
// protobuf_pkg: shared protobuf wire-format definitions.
//   wiretype_*        : wire-type codes carried in the low 3 bits of a key byte
//   VARINT_MAX_BYTES  : longest varint encoding of a 64-bit value
//   enc_state_e       : field encoder FSM states
//   MAKE_KEY          : builds the one-byte key {field_num[4:0], wire_type[2:0]}
package protobuf_pkg;

    localparam logic [2:0] wiretype_varint  = 3'd0;
    localparam logic [2:0] wiretype_fixed64 = 3'd1;
    localparam logic [2:0] wiretype_len     = 3'd2;

    localparam int VARINT_MAX_BYTES = 10;

    typedef enum logic [2:0] {
        ENC_IDLE,
        ENC_KEY,
        ENC_VARINT,
        ENC_FIX64,
        ENC_LENVAR,
        ENC_PAYLOAD
    } enc_state_e;

    function automatic logic [7:0] MAKE_KEY(input logic [4:0] num, input logic [2:0] wtype);
        return {num, wtype};
    endfunction

endpackage

// File: rtl/protobuf_varint_ser.sv
// protobuf_varint_ser: base-128 varint serializer shared by the varint value
// and the length prefix of the field encoder.
//   clk, rst_n  : clock, synchronous active-low reset
//   load        : capture load_value as the remaining value
//   load_value  : value to encode
//   advance     : current byte has been taken, shift to the next 7 bits
//   data        : current byte {more, rem[6:0]}
//   last        : current byte is the final one (no more bits remain)
module protobuf_varint_ser (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [63:0] load_value,
    input  logic        advance,
    output logic [7:0]  data,
    output logic        last
);

    logic [63:0] rem;

    // A zero value still yields one 0x00 byte because last is true at once.
    assign last = (rem[63:7] == '0);
    assign data = {~last, rem[6:0]};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rem <= '0;
        end else if (load) begin
            rem <= load_value;
        end else if (advance) begin
            rem <= rem >> 7;
        end
    end

endmodule

// File: rtl/protobuf_field_encoder.sv
// protobuf_field_encoder: serializes one protobuf field per descriptor into a
// byte stream: key byte, then varint / fixed64 / length prefix + payload.
//   clk, rst_n                          : clock, synchronous active-low reset
//   s_fld_valid/ready/num/wtype/value   : field descriptor handshake
//   s_pld_valid/ready/data              : payload bytes (length-delimited only)
//   m_valid/ready/data/last             : registered output byte stream
//   err_pulse                           : one-cycle pulse on a rejected field
module protobuf_field_encoder
    import protobuf_pkg::*;
#(
    parameter int LEN_W = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        s_fld_valid,
    output logic        s_fld_ready,
    input  logic [4:0]  s_fld_num,
    input  logic [2:0]  s_fld_wtype,
    input  logic [63:0] s_fld_value,
    input  logic        s_pld_valid,
    output logic        s_pld_ready,
    input  logic [7:0]  s_pld_data,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [7:0]  m_data,
    output logic        m_last,
    output logic        err_pulse
);

    enc_state_e       state;
    logic [7:0]       key_q;
    logic [2:0]       wtype_q;
    logic [63:0]      fix_q;
    logic [2:0]       fix_cnt;
    logic [LEN_W-1:0] len_q;

    logic        out_free;
    logic        fld_fire;
    logic        fld_bad;
    logic        ser_load;
    logic        ser_adv;
    logic [63:0] ser_value;
    logic [7:0]  ser_data;
    logic        ser_last;

    function automatic enc_state_e after_key(input logic [2:0] wt);
        if (wt == wiretype_varint)       return ENC_VARINT;
        else if (wt == wiretype_fixed64) return ENC_FIX64;
        else                             return ENC_LENVAR;
    endfunction

    // Output register may take a new byte when empty or being drained.
    assign out_free    = !m_valid || m_ready;
    assign s_fld_ready = (state == ENC_IDLE);
    assign s_pld_ready = (state == ENC_PAYLOAD) && out_free;
    assign fld_fire    = s_fld_valid && s_fld_ready;
    assign fld_bad     = (s_fld_num == 5'd0) || (s_fld_wtype > wiretype_len);
    assign ser_load    = fld_fire && !fld_bad &&
                         (s_fld_wtype == wiretype_varint || s_fld_wtype == wiretype_len);
    assign ser_adv     = out_free && (state == ENC_VARINT || state == ENC_LENVAR);

    always_comb begin
        ser_value = s_fld_value;
        if (s_fld_wtype == wiretype_len) ser_value = 64'(s_fld_value[LEN_W-1:0]);
    end

    protobuf_varint_ser u_varint_ser (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (ser_load),
        .load_value (ser_value),
        .advance    (ser_adv),
        .data       (ser_data),
        .last       (ser_last)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ENC_IDLE;
            m_valid   <= 1'b0;
            m_data    <= '0;
            m_last    <= 1'b0;
            err_pulse <= 1'b0;
            key_q     <= '0;
            wtype_q   <= '0;
            fix_q     <= '0;
            fix_cnt   <= '0;
            len_q     <= '0;
        end else begin
            err_pulse <= 1'b0;
            if (m_ready) m_valid <= 1'b0;

            case (state)
                ENC_IDLE: begin
                    if (fld_fire) begin
                        if (fld_bad) begin
                            err_pulse <= 1'b1;
                        end else begin
                            key_q   <= MAKE_KEY(s_fld_num, s_fld_wtype);
                            wtype_q <= s_fld_wtype;
                            fix_q   <= s_fld_value;
                            fix_cnt <= '0;
                            len_q   <= s_fld_value[LEN_W-1:0];
                            // Load the key straight away when the output is free so
                            // it appears the cycle after accept; otherwise park in KEY.
                            if (out_free) begin
                                m_valid <= 1'b1;
                                m_data  <= MAKE_KEY(s_fld_num, s_fld_wtype);
                                m_last  <= 1'b0;
                                state   <= after_key(s_fld_wtype);
                            end else begin
                                state <= ENC_KEY;
                            end
                        end
                    end
                end
                ENC_KEY: begin
                    if (out_free) begin
                        m_valid <= 1'b1;
                        m_data  <= key_q;
                        m_last  <= 1'b0;
                        state   <= after_key(wtype_q);
                    end
                end
                ENC_VARINT: begin
                    if (out_free) begin
                        m_valid <= 1'b1;
                        m_data  <= ser_data;
                        m_last  <= ser_last;
                        if (ser_last) state <= ENC_IDLE;
                    end
                end
                ENC_LENVAR: begin
                    if (out_free) begin
                        m_valid <= 1'b1;
                        m_data  <= ser_data;
                        // An empty payload ends the field on the length byte.
                        m_last  <= ser_last && (len_q == '0);
                        if (ser_last) state <= (len_q == '0) ? ENC_IDLE : ENC_PAYLOAD;
                    end
                end
                ENC_FIX64: begin
                    if (out_free) begin
                        m_valid <= 1'b1;
                        m_data  <= fix_q[7:0];
                        m_last  <= (fix_cnt == 3'd7);
                        fix_q   <= fix_q >> 8;
                        fix_cnt <= fix_cnt + 3'd1;
                        if (fix_cnt == 3'd7) state <= ENC_IDLE;
                    end
                end
                ENC_PAYLOAD: begin
                    if (s_pld_valid && s_pld_ready) begin
                        m_valid <= 1'b1;
                        m_data  <= s_pld_data;
                        m_last  <= (len_q == LEN_W'(1));
                        len_q   <= len_q - LEN_W'(1);
                        if (len_q == LEN_W'(1)) state <= ENC_IDLE;
                    end
                end
                default: state <= ENC_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_protobuf_field_encoder.sv
// tb_protobuf_field_encoder: directed bench for protobuf_field_encoder.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the
// falling edge. Every transferred output byte is queued as {last, data}.
module tb_protobuf_field_encoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        s_fld_valid;
    logic        s_fld_ready;
    logic [4:0]  s_fld_num;
    logic [2:0]  s_fld_wtype;
    logic [63:0] s_fld_value;
    logic        s_pld_valid;
    logic        s_pld_ready;
    logic [7:0]  s_pld_data;
    logic        m_valid;
    logic        m_ready;
    logic [7:0]  m_data;
    logic        m_last;
    logic        err_pulse;

    int total = 0;
    int bad   = 0;
    int err_cnt = 0;
    int pld_cnt = 0;
    logic [8:0] q[$];

    logic       stall_prev = 1'b0;
    logic [7:0] prev_d;
    logic       prev_l;

    always #5 clk = ~clk;

    protobuf_field_encoder #(.LEN_W(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .s_fld_valid (s_fld_valid),
        .s_fld_ready (s_fld_ready),
        .s_fld_num   (s_fld_num),
        .s_fld_wtype (s_fld_wtype),
        .s_fld_value (s_fld_value),
        .s_pld_valid (s_pld_valid),
        .s_pld_ready (s_pld_ready),
        .s_pld_data  (s_pld_data),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_data      (m_data),
        .m_last      (m_last),
        .err_pulse   (err_pulse)
    );

    // Byte capture, event counters and the stall-hold check.
    always @(negedge clk) begin
        if (!rst_n) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                total++;
                assert (m_valid === 1'b1 && m_data === prev_d && m_last === prev_l)
                else begin
                    bad++;
                    $error("FAIL hold: observed v=%0b d=%0h l=%0b expected v=1 d=%0h l=%0b",
                           m_valid, m_data, m_last, prev_d, prev_l);
                end
            end
            if (m_valid && m_ready) q.push_back({m_last, m_data});
            if (err_pulse) err_cnt++;
            if (s_pld_valid && s_pld_ready) pld_cnt++;
            stall_prev = m_valid && !m_ready;
            prev_d     = m_data;
            prev_l     = m_last;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called aligned 1 unit after a rising edge; returns likewise, one cycle
    // after the accepting edge.
    task automatic send_field(input logic [4:0] n, input logic [2:0] w, input logic [63:0] v);
        int k = 0;
        s_fld_valid = 1'b1;
        s_fld_num   = n;
        s_fld_wtype = w;
        s_fld_value = v;
        @(negedge clk);
        while (!s_fld_ready && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("fld_accept", 64'(s_fld_ready), 64'd1);
        @(posedge clk);
        #1;
        s_fld_valid = 1'b0;
    endtask

    task automatic check_byte(input string tag, input logic [7:0] d, input logic l);
        int k = 0;
        logic [8:0] got;
        while (q.size() == 0 && k < 64) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk({tag, "_present"}, 64'(q.size() != 0), 64'd1);
        if (q.size() != 0) begin
            got = q.pop_front();
            chk(tag, 64'(got), 64'({l, d}));
        end
    endtask

    initial begin
        logic [7:0] pl [3];
        logic       rdy_pat [4];
        int         pidx;
        int         base;

        pl[0] = 8'hAA; pl[1] = 8'hBB; pl[2] = 8'hCC;
        rdy_pat[0] = 1'b1; rdy_pat[1] = 1'b0; rdy_pat[2] = 1'b0; rdy_pat[3] = 1'b1;

        rst_n = 1'b0; m_ready = 1'b0;
        s_fld_valid = 1'b0; s_fld_num = '0; s_fld_wtype = '0; s_fld_value = '0;
        s_pld_valid = 1'b0; s_pld_data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_m_valid", 64'(m_valid), 64'd0);
        chk("rst_m_data", 64'(m_data), 64'd0);
        chk("rst_m_last", 64'(m_last), 64'd0);
        chk("rst_err", 64'(err_pulse), 64'd0);
        chk("rst_pld_ready", 64'(s_pld_ready), 64'd0);
        chk("rst_fld_ready", 64'(s_fld_ready), 64'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        m_ready = 1'b1;

        // 1: varint 150
        send_field(5'd1, 3'd0, 64'd150);
        chk("t1_key_latency", 64'({m_valid, m_data}), 64'h108);
        check_byte("t1_b0", 8'h08, 1'b0);
        check_byte("t1_b1", 8'h96, 1'b0);
        check_byte("t1_b2", 8'h01, 1'b1);
        chk("t1_no_err", 64'(err_cnt), 64'd0);

        // 2: varint 0 and all-ones
        send_field(5'd2, 3'd0, 64'd0);
        check_byte("t2a_key", 8'h10, 1'b0);
        check_byte("t2a_val", 8'h00, 1'b1);
        send_field(5'd31, 3'd0, 64'hFFFF_FFFF_FFFF_FFFF);
        check_byte("t2b_key", 8'hF8, 1'b0);
        for (int i = 0; i < 9; i++) check_byte("t2b_ff", 8'hFF, 1'b0);
        check_byte("t2b_end", 8'h01, 1'b1);

        // 3: fixed64 little-endian
        send_field(5'd3, 3'd1, 64'h0102_0304_0506_0708);
        check_byte("t3_key", 8'h19, 1'b0);
        for (int i = 0; i < 8; i++)
            check_byte("t3_b", 8'(8 - i), (i == 7));

        // 4: length-delimited with stalls and gapped payload
        base = pld_cnt;
        pidx = 0;
        send_field(5'd4, 3'd2, 64'd3);
        for (int c = 0; c < 40; c++) begin
            m_ready     = rdy_pat[c % 4];
            s_pld_valid = (pidx < 3) && (c % 3 != 1);
            s_pld_data  = (pidx < 3) ? pl[pidx] : 8'h00;
            @(negedge clk);
            if (s_pld_valid && s_pld_ready) pidx++;
            @(posedge clk);
            #1;
        end
        s_pld_valid = 1'b0;
        m_ready = 1'b1;
        check_byte("t4_key", 8'h22, 1'b0);
        check_byte("t4_len", 8'h03, 1'b0);
        check_byte("t4_p0", 8'hAA, 1'b0);
        check_byte("t4_p1", 8'hBB, 1'b0);
        check_byte("t4_p2", 8'hCC, 1'b1);
        chk("t4_pld_taken", 64'(pld_cnt - base), 64'd3);
        chk("t4_pld_ready_off", 64'(s_pld_ready), 64'd0);
        chk("t4_no_extra", 64'(q.size()), 64'd0);

        s_pld_valid = 1'b1;
        s_pld_data  = 8'h5A;
        send_field(5'd5, 3'd2, 64'h1234_5678_0000_0000);  // upper bits ignored -> len 0
        check_byte("t4b_key", 8'h2A, 1'b0);
        check_byte("t4b_len", 8'h00, 1'b1);
        chk("t4b_no_pld", 64'(pld_cnt - base), 64'd3);
        s_pld_valid = 1'b0;

        // 5: rejected fields
        base = err_cnt;
        send_field(5'd1, 3'd5, 64'd7);
        chk("t5a_err_hi", 64'(err_pulse), 64'd1);
        @(posedge clk);
        #1;
        chk("t5a_err_lo", 64'(err_pulse), 64'd0);
        chk("t5a_fld_ready", 64'(s_fld_ready), 64'd1);
        send_field(5'd0, 3'd0, 64'd7);
        chk("t5b_err_hi", 64'(err_pulse), 64'd1);
        @(posedge clk);
        #1;
        chk("t5b_err_lo", 64'(err_pulse), 64'd0);
        repeat (4) @(posedge clk);
        #1;
        chk("t5_err_count", 64'(err_cnt - base), 64'd2);
        chk("t5_no_output", 64'(q.size()), 64'd0);
        chk("t5_m_valid", 64'(m_valid), 64'd0);
        send_field(5'd1, 3'd0, 64'd1);
        check_byte("t5c_key", 8'h08, 1'b0);
        check_byte("t5c_val", 8'h01, 1'b1);

        // 6: reset in the middle of a payload
        send_field(5'd1, 3'd2, 64'd5);
        pidx = 0;
        s_pld_valid = 1'b1;
        for (int c = 0; c < 20 && pidx < 2; c++) begin
            s_pld_data = 8'h11 + 8'(pidx);
            @(negedge clk);
            if (s_pld_valid && s_pld_ready) pidx++;
            if (pidx < 2) begin
                @(posedge clk);
                #1;
            end
        end
        chk("t6_two_taken", 64'(pidx), 64'd2);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("t6_m_valid", 64'(m_valid), 64'd0);
        chk("t6_pld_ready", 64'(s_pld_ready), 64'd0);
        chk("t6_fld_ready", 64'(s_fld_ready), 64'd1);
        q.delete();
        base = pld_cnt;
        send_field(5'd1, 3'd0, 64'd1);
        check_byte("t6_key", 8'h08, 1'b0);
        check_byte("t6_val", 8'h01, 1'b1);
        s_pld_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("t6_no_residue", 64'(q.size()), 64'd0);
        chk("t6_no_pld", 64'(pld_cnt - base), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/protobuf_field_encoder.md
Name: protobuf_field_encoder

Overview:
Serializes one protobuf field per transaction into a byte stream. Each field is emitted as a key byte, then either a varint, a fixed 64-bit value, or a length prefix followed by forwarded payload bytes.
It is the transmit-side counterpart of the field parser built on protobuf_pkg and uses the same one-byte key format: {field_num[4:0], wire_type[2:0]}.
It sits between the message-building logic and the outbound byte link.

Parameters:
LEN_W, 32, width of the length-delimited payload length, taken from s_fld_value[LEN_W-1:0]; upper bits are ignored.

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
s_fld_valid  in  1  field descriptor valid
s_fld_ready  out  1  field descriptor accepted when valid&ready
s_fld_num  in  5  field number (1..31)
s_fld_wtype  in  3  wire type: 0 varint, 1 64-bit, 2 length-delimited
s_fld_value  in  64  varint value, fixed64 value, or payload length
s_pld_valid  in  1  payload byte valid (wire type 2 only)
s_pld_ready  out  1  payload byte accepted
s_pld_data  in  8  payload byte
m_valid  out  1  output byte valid
m_ready  in  1  downstream ready
m_data  out  8  output byte
m_last  out  1  marks the final byte of the current field
err_pulse  out  1  one-cycle pulse: field rejected

Behaviour:
- Reset values: m_valid=0, m_data=0, m_last=0, err_pulse=0, s_pld_ready=0, state=IDLE. s_fld_ready=1 after reset.
- Reset mid-field: the partial field is dropped with no completion; the output register is cleared.
- Output register rules (AXI-style):
  - m_data and m_last are registered.
  - While m_valid=1 and m_ready=0, m_data, m_last and m_valid are held stable.
  - A new byte loads when m_valid=0 or m_ready=1, so throughput is 1 byte/clk while m_ready stays high.
- Field acceptance:
  - s_fld_ready=1 only in IDLE.
  - On accept at cycle N, the key byte {num,wtype} appears with m_valid=1 at N+1.
  - wtype, value and length are latched at accept.
- Rejection: wtype not in {0,1,2}, or num=0.
  - The field is accepted but produces no output.
  - err_pulse=1 at N+1; the FSM stays in IDLE.
- FSM states: IDLE -> KEY -> {VARINT | FIX64 | LENVAR} -> (PAYLOAD) -> IDLE.
  - KEY: load the key byte; go to VARINT (wt0), FIX64 (wt1) or LENVAR (wt2).
  - VARINT / LENVAR:
    - byte = {more, rem[6:0]}, where more = (rem>>7)!=0; then rem >>= 7.
    - Value 0 emits a single 0x00.
    - A 64-bit value takes at most 10 bytes.
    - LENVAR encodes the latched length with the same rule.
  - FIX64: 8 bytes, little-endian (value[7:0] first), with a 3-bit byte counter.
  - PAYLOAD:
    - s_pld_ready = (m_valid==0 || m_ready).
    - Each accepted payload byte loads the output register and decrements the remaining count.
    - s_pld_ready drops to 0 in the cycle after the last byte is accepted; no extra bytes are consumed.
- m_last placement:
  - wt0: final varint byte.
  - wt1: 8th byte.
  - wt2 with len>0: last payload byte, and no PAYLOAD state is entered otherwise.
  - wt2 with len=0: final length byte.
- Return to IDLE occurs when the m_last byte is loaded into the output register. The next field may therefore be accepted while that byte is still held; its key byte loads only once m_ready is seen.
- s_pld_valid outside PAYLOAD is ignored, with s_pld_ready=0.

Decomposition:
- Add to protobuf_pkg:
  - MAKE_KEY(num, wtype) function
  - VARINT_MAX_BYTES=10
  - encoder state enum typedef
- Reuse the existing wiretype_* constants.
- One natural sub-module: protobuf_varint_ser, which holds the rem shift register, more-bit and load/advance handshake, and is shared by the VARINT and LENVAR states. The FSM, FIX64 counter and payload counter stay in the top module.

Test Plan:
1. num=1, wt=0, value=150, m_ready=1 -> bytes 0x08, 0x96, 0x01; m_last only on 0x01; err_pulse stays 0.
2. num=2, wt=0, value=0 -> 0x10, 0x00 with m_last on 0x00. Then num=31, wt=0, value=0xFFFF_FFFF_FFFF_FFFF -> 0xF8, then 0xFF x9, then 0x01 (11 bytes total, m_last on 0x01).
3. num=3, wt=1, value=0x0102030405060708 -> 0x19, 08 07 06 05 04 03 02 01; m_last on 0x01.
4. num=4, wt=2, len=3, payload AA BB CC, with m_ready toggling 1,0,0,1 and s_pld_valid gapped -> 0x22 0x03 AA BB CC. No byte is duplicated or lost, data is held during stalls, and m_last is on CC. Then num=5, wt=2, len=0 -> 0x2A 0x00 with m_last on 0x00 and no payload consumed.
5. wt=5 num=1, then wt=0 num=0 -> no m_valid, err_pulse high exactly 1 cycle each, s_fld_ready returns high. A following valid field (num=1, wt=0, value=1) -> 0x08 0x01.
6. Assert rst_n=0 for 1 cycle after 2 payload bytes of a len=5 field -> next cycle m_valid=0, s_pld_ready=0, s_fld_ready=1. A new field (num=1, wt=0, value=1) -> 0x08 0x01, with no residue from the aborted field.
